// File: rtl/qlr_route_broker.sv
// Route-request broker: round-robin admission of NUM_REQ requester channels into a
// small FIFO, serialised one at a time to the Q-learning engine with a per-request timeout.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | waiting for a queued request and an idle engine
// ST_ISSUE | ql_req strobe with the FIFO head's {src,dst}
// ST_WAIT  | waiting for ql_done; down-counter bounds the wait
// ST_RESP  | rsp_valid strobe to the head's channel; head popped
module qlr_route_broker #(
    parameter int NUM_REQ    = 9,
    parameter int ID_W       = 5,
    parameter int ROUTE_W    = 30,
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 255
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*2*ID_W-1:0]     req_sd,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic                          ql_ready,
    output logic                          ql_req,
    output logic [2*ID_W-1:0]             ql_sd,
    input  logic                          ql_done,
    input  logic [ROUTE_W-1:0]            ql_route,
    output logic [NUM_REQ-1:0]            rsp_valid,
    output logic [ROUTE_W-1:0]            rsp_route,
    output logic                          rsp_timeout,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          busy,
    output logic [7:0]                    timeout_cnt
);
    localparam int SD_W  = 2 * ID_W;
    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT, ST_RESP} state_t;

    state_t             state;
    logic [NUM_REQ-1:0] pend;
    logic [IDX_W-1:0]   rr_ptr;
    logic [IDX_W-1:0]   fifo_ch [FIFO_DEPTH];
    logic [SD_W-1:0]    fifo_sd [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [TMR_W-1:0]   wait_left;
    logic [NUM_REQ-1:0] grant;
    logic [IDX_W-1:0]   grant_idx;
    logic               grant_any;
    logic               pop;
    logic               full;
    logic               can_push;
    logic [IDX_W-1:0]   head_ch;
    logic [SD_W-1:0]    head_sd;
    int                 scan;

    assign head_ch = fifo_ch[rd_ptr];
    assign head_sd = fifo_sd[rd_ptr];

    // The RESP pop frees a slot in the same cycle, so a full FIFO may still accept.
    always_comb begin
        pop       = (state == ST_RESP);
        full      = (fifo_count == CNT_W'(FIFO_DEPTH));
        can_push  = !reset && (!full || pop);
        grant     = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        scan      = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            scan = int'(rr_ptr) + k;
            if (scan >= NUM_REQ) scan = scan - NUM_REQ;
            if (!grant_any && can_push && req_valid[scan] && !pend[scan]) begin
                grant_any   = 1'b1;
                grant_idx   = IDX_W'(scan);
                grant[scan] = 1'b1;
            end
        end
        req_ready = grant;
    end

    always_ff @(posedge clk) begin
        if (grant_any) begin
            fifo_ch[wr_ptr] <= grant_idx;
            fifo_sd[wr_ptr] <= req_sd[int'(grant_idx)*SD_W +: SD_W];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pend       <= '0;
            rr_ptr     <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            pend <= (pend | grant) & ~(pop ? rsp_valid : '0);
            if (grant_any) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
                rr_ptr <= (grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx + IDX_W'(1);
            end
            if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
            case ({grant_any, pop})
                2'b10:   fifo_count <= fifo_count + CNT_W'(1);
                2'b01:   fifo_count <= fifo_count - CNT_W'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            ql_req      <= 1'b0;
            ql_sd       <= '0;
            rsp_valid   <= '0;
            rsp_route   <= '0;
            rsp_timeout <= 1'b0;
            busy        <= 1'b0;
            timeout_cnt <= '0;
            wait_left   <= '0;
        end else begin
            ql_req    <= 1'b0;
            rsp_valid <= '0;
            case (state)
                ST_IDLE: begin
                    if (fifo_count != '0 && ql_ready) begin
                        state  <= ST_ISSUE;
                        ql_req <= 1'b1;
                        ql_sd  <= head_sd;
                        busy   <= 1'b1;
                    end
                end
                ST_ISSUE: begin
                    state     <= ST_WAIT;
                    wait_left <= TMR_W'(TIMEOUT - 1);
                end
                ST_WAIT: begin
                    // A done arriving on the last permitted cycle still counts as an answer.
                    if (ql_done) begin
                        state       <= ST_RESP;
                        rsp_valid   <= NUM_REQ'(1) << head_ch;
                        rsp_route   <= ql_route;
                        rsp_timeout <= 1'b0;
                    end else if (wait_left == '0) begin
                        state       <= ST_RESP;
                        rsp_valid   <= NUM_REQ'(1) << head_ch;
                        rsp_route   <= '0;
                        rsp_timeout <= 1'b1;
                        if (timeout_cnt != 8'hFF) timeout_cnt <= timeout_cnt + 8'd1;
                    end else begin
                        wait_left <= wait_left - TMR_W'(1);
                    end
                end
                ST_RESP: begin
                    state       <= ST_IDLE;
                    busy        <= 1'b0;
                    rsp_route   <= '0;
                    rsp_timeout <= 1'b0;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule
